// File: rtl/ex_stage_pkg.sv
// Shared widths, bus layouts, opcode bit positions and divider state encodings
// for the execute stage and its divider.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 154;
  localparam int EX_TO_MEM_WD = 147;
  localparam int EX_TO_ID_WD  = 39;
  localparam int STALL_BUS    = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int MEM_SB = 4;
  localparam int MEM_SH = 3;
  localparam int MEM_SW = 2;
  localparam int MEM_LW = 1;
  localparam int MEM_LH = 0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Field order is MSB first, matching the flat ID->EX bus.
  typedef struct packed {
    logic [1:0]  div_op;
    logic [4:0]  mem_op;
    logic [11:0] alu_op;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_rdata2;
  } id_to_ex_t;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// 32-iteration restoring divider: magnitudes are latched on start, one
// shift-subtract per cycle, signs are reapplied while the result is held.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        ack,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [1:0]  state
);

  div_state_t state_q, state_d;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, divisor;
  logic        neg_q, neg_r;
  logic [32:0] shifted, diff;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_BUSY;
      DIV_BUSY: if (cnt == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (ack) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= DIV_IDLE;
      cnt     <= 5'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && start) begin
        quo     <= signed_op ? abs32(a) : a;
        divisor <= signed_op ? abs32(b) : b;
        rem     <= 32'd0;
        // Divide by zero keeps the all-ones quotient regardless of sign.
        neg_q   <= signed_op && (a[31] ^ b[31]) && (b != 32'd0);
        neg_r   <= signed_op && a[31];
        cnt     <= 5'd0;
      end else if (state_q == DIV_BUSY) begin
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= shifted[31:0];
          quo <= {quo[30:0], 1'b0};
        end
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = neg_q ? (~quo + 32'd1) : quo;
  assign remainder = neg_r ? (~rem + 32'd1) : rem;
  assign state     = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input register, one-hot ALU, data-SRAM request generation,
// iterative divider with front-of-pipe stall request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic [1:0]              div_state
);

  id_to_ex_t   ex_q;
  ex_to_mem_t  mem_s;
  logic [31:0] ex_result;
  logic [31:0] src1, src2;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_q <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      ex_q <= '0;
    end else if (stall[2] == NO_STOP) begin
      ex_q <= id_to_ex_bus;
    end
  end

  assign src1 = ex_q.src1;
  assign src2 = ex_q.src2;

  always_comb begin
    ex_result = 32'd0;
    if (ex_q.alu_op[ALU_ADD])  ex_result = src1 + src2;
    if (ex_q.alu_op[ALU_SUB])  ex_result = src1 - src2;
    if (ex_q.alu_op[ALU_SLT])  ex_result = {31'd0, $signed(src1) < $signed(src2)};
    if (ex_q.alu_op[ALU_SLTU]) ex_result = {31'd0, src1 < src2};
    if (ex_q.alu_op[ALU_AND])  ex_result = src1 & src2;
    if (ex_q.alu_op[ALU_NOR])  ex_result = ~(src1 | src2);
    if (ex_q.alu_op[ALU_OR])   ex_result = src1 | src2;
    if (ex_q.alu_op[ALU_XOR])  ex_result = src1 ^ src2;
    if (ex_q.alu_op[ALU_SLL])  ex_result = src2 << src1[4:0];
    if (ex_q.alu_op[ALU_SRL])  ex_result = src2 >> src1[4:0];
    if (ex_q.alu_op[ALU_SRA])  ex_result = $signed(src2) >>> src1[4:0];
    if (ex_q.alu_op[ALU_LUI])  ex_result = {src2[15:0], 16'd0};
  end

  // Halfword stores to an odd address raise no byte enables at all.
  always_comb begin
    mem_en    = |ex_q.mem_op;
    mem_wen   = 4'b0000;
    mem_wdata = 32'd0;
    if (ex_q.mem_op[MEM_SW]) begin
      mem_wen   = 4'b1111;
      mem_wdata = ex_q.rf_rdata2;
    end else if (ex_q.mem_op[MEM_SH]) begin
      mem_wdata = {2{ex_q.rf_rdata2[15:0]}};
      case (ex_result[1:0])
        2'b00:   mem_wen = 4'b0011;
        2'b10:   mem_wen = 4'b1100;
        default: mem_wen = 4'b0000;
      endcase
    end else if (ex_q.mem_op[MEM_SB]) begin
      mem_wdata = {4{ex_q.rf_rdata2[7:0]}};
      mem_wen   = 4'b0001 << ex_result[1:0];
    end
  end

  assign data_sram_en    = mem_en;
  assign data_sram_wen   = mem_wen;
  assign data_sram_addr  = mem_en ? ex_result : 32'd0;
  assign data_sram_wdata = mem_wdata;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (|ex_q.div_op),
    .abort     (flush),
    .ack       (stall[3] == NO_STOP),
    .signed_op (ex_q.div_op[1]),
    .a         (src1),
    .b         (src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .state     (div_state)
  );

  assign stallreq_for_ex = (|ex_q.div_op) && (div_busy || !div_done);

  always_comb begin
    mem_s              = '0;
    mem_s.hi_we        = div_done;
    mem_s.lo_we        = div_done;
    mem_s.hi           = div_done ? div_rem : 32'd0;
    mem_s.lo           = div_done ? div_quo : 32'd0;
    mem_s.mem_op       = ex_q.mem_op;
    mem_s.pc           = ex_q.pc;
    mem_s.data_ram_en  = mem_en;
    mem_s.data_ram_wen = mem_wen;
    mem_s.sel_rf_res   = ex_q.sel_rf_res;
    mem_s.rf_we        = ex_q.rf_we;
    mem_s.rf_waddr     = ex_q.rf_waddr;
    mem_s.ex_result    = ex_result;
  end

  assign ex_to_mem_bus = mem_s;
  assign ex_to_id_bus  = {ex_q.mem_op[MEM_LW] | ex_q.mem_op[MEM_LH],
                          ex_q.rf_we, ex_q.rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/memory vector table plus hand-written
// divide, flush, bubble and hold sequences.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam logic [11:0] A_ADD = 12'h800, A_SUB = 12'h400, A_SLT = 12'h200,
                          A_SLTU = 12'h100, A_AND = 12'h080, A_NOR = 12'h040,
                          A_OR = 12'h020, A_XOR = 12'h010, A_SLL = 12'h008,
                          A_SRL = 12'h004, A_SRA = 12'h002, A_LUI = 12'h001;
  localparam logic [4:0]  M_SB = 5'h10, M_SH = 5'h08, M_SW = 5'h04,
                          M_LW = 5'h02;

  logic                    clk = 1'b0;
  logic                    rst, flush;
  logic                    auto_stall;
  logic [STALL_BUS-1:0]    stall_man, stall;
  logic [ID_TO_EX_WD-1:0]  id_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    stallreq_for_ex;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr, data_sram_wdata;
  logic [1:0]              div_state;
  ex_to_mem_t              mem_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [11:0] alu;
    logic [4:0]  mem;
    logic [31:0] s1, s2, rd2, res, wdata;
    logic        en;
    logic [3:0]  wen;
  } vec_t;
  vec_t vecs[19];

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .div_state       (div_state)
  );

  // Stand-in for the pipeline controller: stall PC/IF/ID/EX on request.
  assign stall = auto_stall ? {2'b00, {4{stallreq_for_ex}}} : stall_man;
  assign mem_s = ex_to_mem_bus;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ID_TO_EX_WD-1:0] mk(input logic [1:0] dop, input logic [4:0] mop,
                                                 input logic [11:0] aop, input logic [31:0] s1,
                                                 input logic [31:0] s2, input logic [31:0] rd2,
                                                 input logic [4:0] waddr);
    id_to_ex_t t;
    t = '0;
    t.div_op = dop; t.mem_op = mop; t.alu_op = aop;
    t.pc = 32'hBFC0_0000; t.src1 = s1; t.src2 = s2;
    t.rf_we = 1'b1; t.rf_waddr = waddr; t.rf_rdata2 = rd2;
    return t;
  endfunction

  task automatic run_div(input string tag, input logic is_signed, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cyc;
    auto_stall = 1'b1;
    id_bus = mk(is_signed ? 2'b10 : 2'b01, 5'h0, 12'h0, s1, s2, 32'h0, 5'd3);
    tick();
    id_bus = '0;
    cyc = 0;
    while (stallreq_for_ex && cyc < 100) begin
      cyc++;
      tick();
    end
    check({tag, " stall_cycles"}, 160'(cyc), 160'(33));
    check({tag, " stallreq_low"}, 160'(stallreq_for_ex), 160'(1'b0));
    check({tag, " state_done"}, 160'(div_state), 160'(DIV_DONE));
    check({tag, " hilo"}, 160'({mem_s.hi_we, mem_s.lo_we, mem_s.hi, mem_s.lo}),
          160'({1'b1, 1'b1, exp_hi, exp_lo}));
    tick();
    check({tag, " state_idle_after"}, 160'(div_state), 160'(DIV_IDLE));
    check({tag, " hilo_cleared"}, 160'({mem_s.hi_we, mem_s.lo_we, mem_s.hi, mem_s.lo}), 160'(0));
    auto_stall = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{A_ADD,  5'h0, 32'd5,        32'd7,        32'h0, 32'd12,       32'h0, 1'b0, 4'h0};
    vecs[1]  = '{A_SUB,  5'h0, 32'd5,        32'd7,        32'h0, 32'hFFFFFFFE, 32'h0, 1'b0, 4'h0};
    vecs[2]  = '{A_SLT,  5'h0, 32'hFFFFFFFF, 32'd1,        32'h0, 32'd1,        32'h0, 1'b0, 4'h0};
    vecs[3]  = '{A_SLTU, 5'h0, 32'hFFFFFFFF, 32'd1,        32'h0, 32'd0,        32'h0, 1'b0, 4'h0};
    vecs[4]  = '{A_AND,  5'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 32'h0, 1'b0, 4'h0};
    vecs[5]  = '{A_NOR,  5'h0, 32'h0F0F0F0F, 32'hF0000000, 32'h0, 32'h00F0F0F0, 32'h0, 1'b0, 4'h0};
    vecs[6]  = '{A_OR,   5'h0, 32'h12340000, 32'h00005678, 32'h0, 32'h12345678, 32'h0, 1'b0, 4'h0};
    vecs[7]  = '{A_XOR,  5'h0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'hF0F00F0F, 32'h0, 1'b0, 4'h0};
    vecs[8]  = '{A_SLL,  5'h0, 32'd4,        32'h000000FF, 32'h0, 32'h00000FF0, 32'h0, 1'b0, 4'h0};
    vecs[9]  = '{A_SRL,  5'h0, 32'd4,        32'h80000000, 32'h0, 32'h08000000, 32'h0, 1'b0, 4'h0};
    vecs[10] = '{A_SRA,  5'h0, 32'd4,        32'h80000000, 32'h0, 32'hF8000000, 32'h0, 1'b0, 4'h0};
    vecs[11] = '{A_LUI,  5'h0, 32'd9,        32'h0000ABCD, 32'h0, 32'hABCD0000, 32'h0, 1'b0, 4'h0};
    vecs[12] = '{12'h0,  5'h0, 32'd5,        32'd7,        32'h0, 32'd0,        32'h0, 1'b0, 4'h0};
    vecs[13] = '{A_ADD, M_SH, 32'h1000, 32'h2, 32'hABCD1234, 32'h1002, 32'h12341234, 1'b1, 4'b1100};
    vecs[14] = '{A_ADD, M_SH, 32'h1000, 32'h1, 32'hABCD1234, 32'h1001, 32'h12341234, 1'b1, 4'b0000};
    vecs[15] = '{A_ADD, M_SH, 32'h1000, 32'h0, 32'hABCD1234, 32'h1000, 32'h12341234, 1'b1, 4'b0011};
    vecs[16] = '{A_ADD, M_SB, 32'h1000, 32'h3, 32'hABCD1234, 32'h1003, 32'h34343434, 1'b1, 4'b1000};
    vecs[17] = '{A_ADD, M_SW, 32'h2000, 32'h4, 32'hDEADBEEF, 32'h2004, 32'hDEADBEEF, 1'b1, 4'b1111};
    vecs[18] = '{A_ADD, M_LW, 32'h2000, 32'h8, 32'hDEADBEEF, 32'h2008, 32'h00000000, 1'b1, 4'b0000};

    // Clock/reset.
    rst = 1'b1; flush = 1'b0; auto_stall = 1'b0; stall_man = '0; id_bus = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset ex_to_mem", 160'(ex_to_mem_bus), 160'(0));
    check("reset ex_to_id", 160'(ex_to_id_bus), 160'(0));
    check("reset sram", 160'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 160'(0));
    check("reset stallreq", 160'(stallreq_for_ex), 160'(1'b0));
    check("reset div_state", 160'(div_state), 160'(DIV_IDLE));

    // One register of latency: nothing appears before the edge.
    id_bus = mk(2'b00, 5'h0, A_ADD, 32'd5, 32'd7, 32'h0, 5'd1);
    #2;
    check("add before edge", 160'(mem_s.ex_result), 160'(0));
    tick();
    check("add after edge", 160'(mem_s.ex_result), 160'(32'd12));

    for (int i = 0; i < 19; i++) begin
      id_bus = mk(2'b00, vecs[i].mem, vecs[i].alu, vecs[i].s1, vecs[i].s2, vecs[i].rd2, 5'(i));
      exp_q.push_back(vecs[i].res);
      tick();
      begin
        logic [31:0] exp_res;
        logic        exp_ld;
        exp_res = exp_q.pop_front();
        exp_ld  = vecs[i].mem[1] | vecs[i].mem[0];
        check($sformatf("v%0d result", i), 160'(mem_s.ex_result), 160'(exp_res));
        check($sformatf("v%0d sram_en", i), 160'(data_sram_en), 160'(vecs[i].en));
        check($sformatf("v%0d sram_wen", i), 160'(data_sram_wen), 160'(vecs[i].wen));
        check($sformatf("v%0d sram_addr", i), 160'(data_sram_addr),
              160'(vecs[i].en ? exp_res : 32'h0));
        check($sformatf("v%0d sram_wdata", i), 160'(data_sram_wdata), 160'(vecs[i].wdata));
        check($sformatf("v%0d bus_mem", i), 160'({mem_s.data_ram_en, mem_s.data_ram_wen, mem_s.mem_op}),
              160'({vecs[i].en, vecs[i].wen, vecs[i].mem}));
        check($sformatf("v%0d hilo_zero", i),
              160'({mem_s.hi_we, mem_s.lo_we, mem_s.hi, mem_s.lo}), 160'(0));
        check($sformatf("v%0d ex_to_id", i), 160'(ex_to_id_bus),
              160'({exp_ld, 1'b1, 5'(i), exp_res}));
      end
    end

    // Divides, back to back.
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_ff_0", 1'b0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);

    // Flush ten cycles into a divide.
    auto_stall = 1'b1;
    id_bus = mk(2'b10, 5'h0, 12'h0, 32'd100, 32'd7, 32'h0, 5'd4);
    tick();
    id_bus = '0;
    repeat (10) tick();
    check("flush pre busy", 160'(div_state), 160'(DIV_BUSY));
    check("flush pre stallreq", 160'(stallreq_for_ex), 160'(1'b1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush stallreq", 160'(stallreq_for_ex), 160'(1'b0));
    check("flush state", 160'(div_state), 160'(DIV_IDLE));
    check("flush ex_to_mem", 160'(ex_to_mem_bus), 160'(0));
    check("flush ex_to_id", 160'(ex_to_id_bus), 160'(0));
    auto_stall = 1'b0;
    tick();
    check("flush stays idle", 160'(div_state), 160'(DIV_IDLE));

    // ID stalled while EX runs: the register takes a bubble.
    stall_man = '0;
    id_bus = mk(2'b00, M_LW, A_ADD, 32'h3000, 32'h10, 32'h0, 5'd9);
    tick();
    check("lw sram_en", 160'(data_sram_en), 160'(1'b1));
    check("lw addr", 160'(data_sram_addr), 160'(32'h3010));
    check("lw is_load", 160'(ex_to_id_bus[38]), 160'(1'b1));
    id_bus = mk(2'b00, M_LW, A_ADD, 32'h4000, 32'h20, 32'h0, 5'd10);
    stall_man = 6'b000111;
    tick();
    check("bubble sram_en", 160'(data_sram_en), 160'(1'b0));
    check("bubble ex_to_mem", 160'(ex_to_mem_bus), 160'(0));
    check("bubble ex_to_id", 160'(ex_to_id_bus), 160'(0));

    // ID and EX both stalled: the register holds.
    stall_man = '0;
    id_bus = mk(2'b00, 5'h0, A_ADD, 32'd1, 32'd2, 32'h0, 5'd11);
    tick();
    id_bus = mk(2'b00, 5'h0, A_ADD, 32'd10, 32'd20, 32'h0, 5'd12);
    stall_man = 6'b001111;
    tick();
    check("hold result", 160'(mem_s.ex_result), 160'(32'd3));
    check("hold waddr", 160'(mem_s.rf_waddr), 160'(5'd11));
    stall_man = '0;
    tick();
    check("release result", 160'(mem_s.ex_result), 160'(32'd30));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
